// File: rtl/alu_pkg.sv
// Shared encodings for the operand-2 shifter / ALU / NZCV flag datapath.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;
  localparam logic [2:0] ALU_MOV = 3'b101;
  localparam logic [2:0] ALU_BIC = 3'b110;
  localparam logic [2:0] ALU_MVN = 3'b111;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // Bit positions inside the 4-bit {N,Z,C,V} vectors.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/barrel_shifter.sv
// Combinational operand-2 barrel shifter (LSL/LSR/ASR/ROR with the
// shamt=0 special encodings LSR#32, ASR#32 and RRX) plus shifter carry-out.
module barrel_shifter
  import alu_pkg::*;
(
  input  logic [11:0] op2_field,
  input  logic [31:0] rd2,
  input  logic        cin,
  output logic [31:0] shift_result,
  output logic        shift_carry
);

  logic [4:0] shamt;
  logic [1:0] sh_type;
  logic [4:0] left_idx;
  logic [4:0] right_idx;
  logic       unused_bits;

  assign shamt       = op2_field[11:7];
  assign sh_type     = op2_field[6:5];
  assign unused_bits = ^op2_field[4:0];

  // For shamt in 1..31 these wrap to 32-n and n-1, the last bit shifted out.
  assign left_idx  = 5'd0 - shamt;
  assign right_idx = shamt - 5'd1;

  always_comb begin
    shift_result = rd2;
    shift_carry  = cin;
    case (sh_type)
      SH_LSL: begin
        if (shamt != 5'd0) begin
          shift_result = rd2 << shamt;
          shift_carry  = rd2[left_idx];
        end
      end
      SH_LSR: begin
        if (shamt == 5'd0) begin
          shift_result = 32'h0000_0000;
          shift_carry  = rd2[31];
        end else begin
          shift_result = rd2 >> shamt;
          shift_carry  = rd2[right_idx];
        end
      end
      SH_ASR: begin
        if (shamt == 5'd0) begin
          shift_result = {32{rd2[31]}};
          shift_carry  = rd2[31];
        end else begin
          shift_result = $signed(rd2) >>> shamt;
          shift_carry  = rd2[right_idx];
        end
      end
      default: begin
        if (shamt == 5'd0) begin
          shift_result = {cin, rd2[31:1]};
          shift_carry  = rd2[0];
        end else begin
          shift_result = (rd2 >> shamt) | (rd2 << left_idx);
          shift_carry  = rd2[right_idx];
        end
      end
    endcase
  end

endmodule

// File: rtl/alu_shift_unit.sv
// Operand-B select, 32-bit ALU, combinational NZCV and the registered flags.
// Cin and the held V always come from the registered flags, so no loop exists.
module alu_shift_unit
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] op2_field,
  input  logic [31:0] rd2,
  input  logic [31:0] ext_imm,
  input  logic        alu_src,
  input  logic [31:0] src_a,
  input  logic [2:0]  alu_control,
  input  logic        flag_write,
  output logic [31:0] shift_result,
  output logic [31:0] src_b,
  output logic [31:0] alu_result,
  output logic [3:0]  alu_flags,
  output logic [3:0]  flags
);

  logic [3:0]  flags_q;
  logic [3:0]  flags_d;
  logic        cin;
  logic        shift_carry;
  logic        sc;
  logic [31:0] b_eff;
  logic [32:0] sum;
  logic        is_arith;

  assign cin = flags_q[FLAG_C];

  barrel_shifter u_shifter (
    .op2_field    (op2_field),
    .rd2          (rd2),
    .cin          (cin),
    .shift_result (shift_result),
    .shift_carry  (shift_carry)
  );

  assign src_b = alu_src ? ext_imm : shift_result;
  assign sc    = alu_src ? cin : shift_carry;

  // SUB reuses the adder as a + ~b + 1, so C=1 means no borrow.
  assign is_arith = (alu_control == ALU_ADD) || (alu_control == ALU_SUB);
  assign b_eff    = (alu_control == ALU_SUB) ? ~src_b : src_b;
  assign sum      = {1'b0, src_a} + {1'b0, b_eff} + {32'd0, (alu_control == ALU_SUB)};

  always_comb begin
    alu_result = sum[31:0];
    case (alu_control)
      ALU_AND: alu_result = src_a & src_b;
      ALU_ORR: alu_result = src_a | src_b;
      ALU_EOR: alu_result = src_a ^ src_b;
      ALU_MOV: alu_result = src_b;
      ALU_BIC: alu_result = src_a & ~src_b;
      ALU_MVN: alu_result = ~src_b;
      default: alu_result = sum[31:0];
    endcase
  end

  always_comb begin
    alu_flags         = 4'b0000;
    alu_flags[FLAG_N] = alu_result[31];
    alu_flags[FLAG_Z] = (alu_result == 32'h0000_0000);
    if (is_arith) begin
      alu_flags[FLAG_C] = sum[32];
      alu_flags[FLAG_V] = (src_a[31] == b_eff[31]) && (alu_result[31] != src_a[31]);
    end else begin
      alu_flags[FLAG_C] = sc;
      alu_flags[FLAG_V] = flags_q[FLAG_V];
    end
  end

  assign flags_d = flag_write ? alu_flags : flags_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) flags_q <= 4'b0000;
    else       flags_q <= flags_d;
  end

  assign flags = flags_q;

endmodule

// File: tb/tb_alu_shift_unit.sv
// Directed vector table for the shifter/ALU with flags held at 0000, followed
// by hand-written sequences for flag latching, carry-in use and async reset.
module tb_alu_shift_unit;

  logic        clk;
  logic        reset;
  logic [11:0] op2_field;
  logic [31:0] rd2;
  logic [31:0] ext_imm;
  logic        alu_src;
  logic [31:0] src_a;
  logic [2:0]  alu_control;
  logic        flag_write;
  logic [31:0] shift_result;
  logic [31:0] src_b;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;
  logic [3:0]  flags;

  int n_cmp = 0;
  int n_err = 0;

  alu_shift_unit dut (
    .clk          (clk),
    .reset        (reset),
    .op2_field    (op2_field),
    .rd2          (rd2),
    .ext_imm      (ext_imm),
    .alu_src      (alu_src),
    .src_a        (src_a),
    .alu_control  (alu_control),
    .flag_write   (flag_write),
    .shift_result (shift_result),
    .src_b        (src_b),
    .alu_result   (alu_result),
    .alu_flags    (alu_flags),
    .flags        (flags)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] op2;
    logic [31:0] rd2;
    logic [31:0] ext;
    logic [31:0] a;
    logic        src;
    logic [2:0]  ctl;
    logic [31:0] exp_sh;
    logic [31:0] exp_res;
    logic [3:0]  exp_fl;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [11:0] op2, input logic [31:0] r2, input logic [31:0] ext,
                       input logic [31:0] a, input logic src, input logic [2:0] ctl,
                       input logic fw);
    op2_field   = op2;
    rd2         = r2;
    ext_imm     = ext;
    src_a       = a;
    alu_src     = src;
    alu_control = ctl;
    flag_write  = fw;
  endtask

  initial begin
    // Fields: op2, rd2, ext, a, src, ctl, exp_sh, exp_res, exp_fl (flags held 0000)
    vecs[0]  = '{12'h080, 32'h8000_0001, 32'h0, 32'h0,         1'b0, 3'b101, 32'h0000_0002, 32'h0000_0002, 4'b0010};
    vecs[1]  = '{12'h040, 32'h8000_0000, 32'h0, 32'h0,         1'b0, 3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1010};
    vecs[2]  = '{12'h020, 32'h8000_0000, 32'h0, 32'h0,         1'b0, 3'b101, 32'h0000_0000, 32'h0000_0000, 4'b0110};
    vecs[3]  = '{12'h000, 32'h0,         32'h1, 32'h7FFF_FFFF, 1'b1, 3'b000, 32'h0000_0000, 32'h8000_0000, 4'b1001};
    vecs[4]  = '{12'h000, 32'h0,         32'h5, 32'h5,         1'b1, 3'b001, 32'h0000_0000, 32'h0000_0000, 4'b0110};
    vecs[5]  = '{12'h000, 32'h0,         32'h5, 32'h3,         1'b1, 3'b001, 32'h0000_0000, 32'hFFFF_FFFE, 4'b1000};
    vecs[6]  = '{12'h01F, 32'h0000_1234, 32'h0, 32'h0001_0000, 1'b0, 3'b011, 32'h0000_1234, 32'h0001_1234, 4'b0000};
    vecs[7]  = '{12'h260, 32'h0000_00F1, 32'h0, 32'h1000_000F, 1'b0, 3'b100, 32'h1000_000F, 32'h0000_0000, 4'b0100};
    vecs[8]  = '{12'h220, 32'h0000_0018, 32'h0, 32'h0000_00FF, 1'b0, 3'b110, 32'h0000_0001, 32'h0000_00FE, 4'b0010};
    vecs[9]  = '{12'h240, 32'h8000_0008, 32'h0, 32'h0,         1'b0, 3'b111, 32'hF800_0000, 32'h07FF_FFFF, 4'b0010};
    vecs[10] = '{12'hF80, 32'h0000_0003, 32'h0, 32'hFFFF_FFFF, 1'b0, 3'b010, 32'h8000_0000, 32'h8000_0000, 4'b1010};
    vecs[11] = '{12'h000, 32'h0,         32'h1, 32'hFFFF_FFFF, 1'b1, 3'b000, 32'h0000_0000, 32'h0000_0000, 4'b0110};
    vecs[12] = '{12'h000, 32'h0,         32'h1, 32'h8000_0000, 1'b1, 3'b001, 32'h0000_0000, 32'h7FFF_FFFF, 4'b0011};
    vecs[13] = '{12'h060, 32'h0000_0003, 32'h0, 32'h0,         1'b0, 3'b101, 32'h0000_0001, 32'h0000_0001, 4'b0010};

    reset = 1'b1;
    drive(12'h000, 32'h0, 32'h0, 32'h0, 1'b0, 3'b000, 1'b0);
    repeat (2) @(posedge clk);
    #1 check("reset_flags", {28'd0, flags}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Table: flag_write=0 throughout, so flags stay 0000.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vecs[i].op2, vecs[i].rd2, vecs[i].ext, vecs[i].a, vecs[i].src, vecs[i].ctl, 1'b0);
      #1;
      check($sformatf("v%0d_shift", i), shift_result, vecs[i].exp_sh);
      check($sformatf("v%0d_srcb", i), src_b, vecs[i].src ? vecs[i].ext : vecs[i].exp_sh);
      check($sformatf("v%0d_res", i), alu_result, vecs[i].exp_res);
      check($sformatf("v%0d_flags", i), {28'd0, alu_flags}, {28'd0, vecs[i].exp_fl});
    end
    @(posedge clk);
    #1 check("hold_after_table", {28'd0, flags}, 32'h0);

    // LSL #1 MOV with flag_write latches 0010.
    @(negedge clk);
    drive(12'h080, 32'h8000_0001, 32'h0, 32'h0, 1'b0, 3'b101, 1'b1);
    #1 check("lsl1_alu_flags", {28'd0, alu_flags}, 32'h2);
    @(posedge clk);
    #1 check("lsl1_latched", {28'd0, flags}, 32'h2);

    // RRX with C=1, flag_write=0: flags must hold.
    @(negedge clk);
    drive(12'h060, 32'h0000_0002, 32'h0, 32'h0, 1'b0, 3'b101, 1'b0);
    #1;
    check("rrx_shift", shift_result, 32'h8000_0001);
    check("rrx_alu_flags", {28'd0, alu_flags}, 32'h8);
    @(posedge clk);
    #1 check("rrx_hold", {28'd0, flags}, 32'h2);

    // Same-cycle write/read: ROR#0 of 0 sees old C=1, then latches 1000.
    @(negedge clk);
    drive(12'h060, 32'h0, 32'h0, 32'h0, 1'b0, 3'b101, 1'b1);
    #1 check("rrx_old_cin", shift_result, 32'h8000_0000);
    @(posedge clk);
    #1 check("rrx_latched", {28'd0, flags}, 32'h8);
    @(negedge clk);
    drive(12'h060, 32'h0, 32'h0, 32'h0, 1'b0, 3'b101, 1'b0);
    #1 check("rrx_new_cin", shift_result, 32'h0);

    // Build flags=0001: ADD overflow (1001), then ORR keeps V, clears N, C=Cin=0.
    @(negedge clk);
    drive(12'h000, 32'h0, 32'h1, 32'h7FFF_FFFF, 1'b1, 3'b000, 1'b1);
    @(posedge clk);
    #1 check("add_ovf_latched", {28'd0, flags}, 32'h9);
    @(negedge clk);
    drive(12'h000, 32'h0, 32'h1, 32'h1, 1'b1, 3'b011, 1'b1);
    @(posedge clk);
    #1 check("orr_latched", {28'd0, flags}, 32'h1);

    // AND with V held: result 0, alu_flags 0101.
    @(negedge clk);
    drive(12'h000, 32'h0, 32'h0F, 32'hF0, 1'b1, 3'b010, 1'b0);
    #1;
    check("and_res", alu_result, 32'h0);
    check("and_alu_flags", {28'd0, alu_flags}, 32'h5);
    @(posedge clk);
    #1 check("and_hold", {28'd0, flags}, 32'h1);

    // Asynchronous reset between edges.
    #2 reset = 1'b1;
    #1 check("async_reset", {28'd0, flags}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(12'h080, 32'h8000_0001, 32'h0, 32'h0, 1'b0, 3'b101, 1'b0);
    @(posedge clk);
    #1 check("post_reset_hold", {28'd0, flags}, 32'h0);
    @(negedge clk);
    flag_write = 1'b1;
    @(posedge clk);
    #1 check("post_reset_first_write", {28'd0, flags}, 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_shift_unit.md
# alu_shift_unit

Combined operand-2 barrel shifter, 32-bit ALU and NZCV flag register for the single-cycle ARM-subset datapath. The unit takes the register operand and its 12-bit shift field and selects either the shifted value or the extended immediate as operand B. It then computes the ALU result and flags combinationally. The flags are latched into a status register on request. It sits between the register file read ports and the result/PC muxes.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  clock; flag register updates on rising edge.
- reset  in  1  asynchronous, active-high; clears flag register.
- op2_field  in  12  instruction bits [11:0]: [11:7] shamt5, [6:5] shift type, [4] must be 0 (ignored), [3:0] unused here.
- rd2  in  32  register operand to be shifted.
- ext_imm  in  32  extended immediate.
- alu_src  in  1  1: operand B = ext_imm; 0: operand B = shift_result.
- src_a  in  32  ALU operand A.
- alu_control  in  3  operation select.
- flag_write  in  1  latch alu_flags into flags at next edge.
- shift_result  out  32  shifter output (combinational).
- src_b  out  32  selected operand B (combinational).
- alu_result  out  32  ALU result (combinational).
- alu_flags  out  4  {N,Z,C,V} of the current operation (combinational).
- flags  out  4  registered {N,Z,C,V}; reset value 4'b0000.

## Operation
- Shifter, sh = [6:5], n = shamt5, Cin = flags[1]:
  - 00 LSL: n=0 → rd2, carry Cin; else rd2<<n, carry rd2[32-n].
  - 01 LSR: n=0 means 32 → 0, carry rd2[31]; else rd2>>n, carry rd2[n-1].
  - 10 ASR: n=0 means 32 → all bits = rd2[31], carry rd2[31]; else arithmetic shift, carry rd2[n-1].
  - 11 ROR: n=0 is RRX → {Cin, rd2[31:1]}, carry rd2[0]; else rotate right n, carry rd2[n-1].
- Operand B: src_b = alu_src ? ext_imm : shift_result. Shifter carry sc = alu_src ? Cin : shifter carry.
- alu_control:
  - 000 ADD: a+b.
  - 001 SUB: a-b = a+~b+1.
  - 010 AND.
  - 011 ORR.
  - 100 EOR.
  - 101 MOV: b.
  - 110 BIC: a&~b.
  - 111 MVN: ~b.
- N = result[31]. Z = (result==0).
- ADD/SUB:
  - C = carry out of the 33-bit sum. For SUB, C=1 means no borrow.
  - V = signed overflow, i.e. operand signs (b inverted for SUB) equal and result sign differs.
- Logic ops (010–111): C = sc, V = flags[0] (unchanged).
- flags holds its value when flag_write=0.
- Shifter and ALU read Cin/V from registered flags, never from alu_flags. There is no combinational loop.

## Timing
- Shifter, mux, ALU and alu_flags: purely combinational, zero latency, valid within the same cycle as the inputs.
- flags: one register. Reset asserted at any time forces 0000 immediately. Otherwise on a rising clk edge with flag_write=1, flags ← alu_flags.
- An operation that reads Cin in cycle k sees flags written at the end of cycle k-1 or earlier. Write and read in the same cycle use the old value.
- Reset deasserted mid-sequence: first update occurs at the first edge with flag_write=1.

## Structure
- Shared package alu_pkg: alu_control encodings (ALU_ADD…ALU_MVN), shift type encodings (SH_LSL, SH_LSR, SH_ASR, SH_ROR), flag bit indices (N=3, Z=2, C=1, V=0).
- One sub-module, barrel_shifter: combinational, with inputs op2_field, rd2, cin and outputs shift_result, shift_carry.
- The ALU, flag logic and flag register live in the top module.

## Test plan
- rd2=0x8000_0001, LSL #1, alu_src=0, MOV, flag_write=1 → shift_result=0x0000_0002. Flags latched = 0010: N=0, Z=0, C=1, V=0.
- rd2=0x8000_0000, ASR with shamt 0 (ASR #32) → shift_result=0xFFFF_FFFF, carry 1. Same rd2 with LSR #0 → 0x0000_0000, carry 1.
- Flags C=1, rd2=0x0000_0002, ROR with shamt 0 (RRX) → shift_result=0x8000_0001, carry 0.
- ADD with a=0x7FFF_FFFF, b=ext_imm=1, alu_src=1 → alu_result=0x8000_0000, alu_flags 1001.
- SUB with a=5, b=5 → 0, flags 0110. SUB with a=3, b=5 → 0xFFFF_FFFE, flags 1000.
- Flags=0001 (V set), AND with a=0xF0, b=0x0F, alu_src=1 → alu_result 0, alu_flags 0101.
- flag_write=0 leaves flags unchanged.
- Asserting reset between edges clears flags to 0000 without a clock edge.
